rename_unit: RTL and testbench

- Register-rename stage directly downstream of the ID/EX pipeline register.
- Consumes decoded architectural source and destination registers plus regWrite, and maps them to physical registers through a register alias table (RAT).
- Allocates new destination physical registers from a circular free list and returns them on retire.
- Emits registered physical tags to the reservation-station / ROB dispatch logic.

---
 rtl/rename_unit.sv | 146 ++++++++++++++
 tb/tb_rename_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_unit.sv
// Purpose : register rename; maps arch rs1/rs2/rd to physical tags via a RAT and
//           allocates rd tags from a circular free list refilled by ROB retire.
// Latency : 1 cycle, valid_in to valid_out; outputs hold while stall_in is high.
// Backpressure: ready_out drops on stall_in or an empty free list; retire is never stalled.
//
// Ports:
//   clk, rstn                      clock, async active-low reset
//   valid_in, srcReg1_in, srcReg2_in, destReg_in, regWrite_in   decoded instruction
//   stall_in / ready_out           downstream stall / rename can accept
//   valid_out, srcPhys1_out, srcPhys2_out, destPhys_out, oldDestPhys_out   registered tags
//   retire_valid, retire_phys      tag returned to the free list by the ROB
//   free_count_out                 free-list occupancy
//   error_out                      sticky free-list overflow flag
module rename_unit #(
    parameter int ARCH_REGS  = 32,
    parameter int PHYS_REGS  = 64,
    parameter int PREG_W     = 6,
    parameter int FREE_DEPTH = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              valid_in,
    input  logic [4:0]        srcReg1_in,
    input  logic [4:0]        srcReg2_in,
    input  logic [4:0]        destReg_in,
    input  logic              regWrite_in,
    input  logic              stall_in,
    output logic              ready_out,
    output logic              valid_out,
    output logic [PREG_W-1:0] srcPhys1_out,
    output logic [PREG_W-1:0] srcPhys2_out,
    output logic [PREG_W-1:0] destPhys_out,
    output logic [PREG_W-1:0] oldDestPhys_out,
    input  logic              retire_valid,
    input  logic [PREG_W-1:0] retire_phys,
    output logic [PREG_W:0]   free_count_out,
    output logic              error_out
);

    localparam int FPTR_W = $clog2(FREE_DEPTH);
    localparam logic [PREG_W:0] FULL_COUNT = (PREG_W+1)'(FREE_DEPTH);

    // RAT entry 0 (x0) is not stored: reads of x0 always return tag 0.
    logic [PREG_W-1:0] rat [1:ARCH_REGS-1];
    logic [PREG_W-1:0] freeList [FREE_DEPTH];

    logic [FPTR_W-1:0] head;
    logic [FPTR_W-1:0] tail;
    logic [PREG_W:0]   freeCount;

    logic              accept;
    logic              alloc;
    logic              retAccept;
    logic              retDrop;
    logic              retWrite;
    logic [PREG_W-1:0] ratSrc1;
    logic [PREG_W-1:0] ratSrc2;
    logic [PREG_W-1:0] ratDest;

    function automatic logic [FPTR_W-1:0] ptrInc(input logic [FPTR_W-1:0] p);
        return (p == FPTR_W'(FREE_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // ready_out only looks at the registered count, so a retire in the same
    // cycle as an empty free list does not let an instruction through.
    assign ready_out = !stall_in && (freeCount != '0);
    assign accept    = valid_in && ready_out;
    assign alloc     = accept && regWrite_in && (destReg_in != 5'd0);

    assign retAccept = retire_valid && (retire_phys != '0);
    // A retire into a full list is only legal if an allocation frees a slot
    // in the same cycle; otherwise it is dropped and flagged.
    assign retDrop   = retAccept && (freeCount == FULL_COUNT) && !alloc;
    assign retWrite  = retAccept && !retDrop;

    assign free_count_out = freeCount;

    // RAT read ports; these see the mapping before this cycle's update, which
    // gives "add x1,x1,x2" the old x1 tag.
    always_comb begin
        ratSrc1 = '0;
        ratSrc2 = '0;
        ratDest = '0;
        for (int i = 1; i < ARCH_REGS; i++) begin
            if (srcReg1_in == 5'(i)) ratSrc1 = rat[i];
            if (srcReg2_in == 5'(i)) ratSrc2 = rat[i];
            if (destReg_in == 5'(i)) ratDest = rat[i];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 1; i < ARCH_REGS; i++) begin
                rat[i] <= PREG_W'(i);
            end
        end else begin
            for (int i = 1; i < ARCH_REGS; i++) begin
                if (alloc && destReg_in == 5'(i)) rat[i] <= freeList[head];
            end
        end
    end

    // Free list: head is read by allocation, tail is written by retire. When
    // both hit the same slot (list full) the nonblocking write lands after
    // the read, so the allocation gets the old entry.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FREE_DEPTH; i++) begin
                freeList[i] <= PREG_W'(PHYS_REGS - FREE_DEPTH + i);
            end
            head      <= '0;
            tail      <= '0;
            freeCount <= FULL_COUNT;
            error_out <= 1'b0;
        end else begin
            if (alloc) head <= ptrInc(head);
            if (retWrite) begin
                freeList[tail] <= retire_phys;
                tail           <= ptrInc(tail);
            end
            case ({retWrite, alloc})
                2'b10:   freeCount <= freeCount + 1'b1;
                2'b01:   freeCount <= freeCount - 1'b1;
                default: freeCount <= freeCount;
            endcase
            if (retDrop) error_out <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_out       <= 1'b0;
            srcPhys1_out    <= '0;
            srcPhys2_out    <= '0;
            destPhys_out    <= '0;
            oldDestPhys_out <= '0;
        end else if (!stall_in) begin
            valid_out       <= accept;
            srcPhys1_out    <= ratSrc1;
            srcPhys2_out    <= ratSrc2;
            destPhys_out    <= alloc ? freeList[head] : '0;
            oldDestPhys_out <= alloc ? ratDest : '0;
        end
    end

endmodule

// File: tb/tb_rename_unit.sv
module tb_rename_unit;

    logic       clk = 1'b0;
    logic       rstn;
    logic       valid_in;
    logic [4:0] srcReg1_in;
    logic [4:0] srcReg2_in;
    logic [4:0] destReg_in;
    logic       regWrite_in;
    logic       stall_in;
    logic       ready_out;
    logic       valid_out;
    logic [5:0] srcPhys1_out;
    logic [5:0] srcPhys2_out;
    logic [5:0] destPhys_out;
    logic [5:0] oldDestPhys_out;
    logic       retire_valid;
    logic [5:0] retire_phys;
    logic [6:0] free_count_out;
    logic       error_out;

    rename_unit dut (
        .clk             (clk),
        .rstn            (rstn),
        .valid_in        (valid_in),
        .srcReg1_in      (srcReg1_in),
        .srcReg2_in      (srcReg2_in),
        .destReg_in      (destReg_in),
        .regWrite_in     (regWrite_in),
        .stall_in        (stall_in),
        .ready_out       (ready_out),
        .valid_out       (valid_out),
        .srcPhys1_out    (srcPhys1_out),
        .srcPhys2_out    (srcPhys2_out),
        .destPhys_out    (destPhys_out),
        .oldDestPhys_out (oldDestPhys_out),
        .retire_valid    (retire_valid),
        .retire_phys     (retire_phys),
        .free_count_out  (free_count_out),
        .error_out       (error_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] s1;
        logic [5:0] s2;
        logic [5:0] d;
        logic [5:0] o;
    } expT;

    expT  expQ[$];
    expT  lastExp;
    logic haveLast = 1'b0;
    logic upd = 1'b0;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int v, input int s1, input int s2, input int d, input int rw,
                         input int st, input int rv, input int rp);
        valid_in     = (v != 0);
        srcReg1_in   = 5'(s1);
        srcReg2_in   = 5'(s2);
        destReg_in   = 5'(d);
        regWrite_in  = (rw != 0);
        stall_in     = (st != 0);
        retire_valid = (rv != 0);
        retire_phys  = 6'(rp);
    endtask

    task automatic expectOut(input int s1, input int s2, input int d, input int o);
        expQ.push_back({6'(s1), 6'(s2), 6'(d), 6'(o)});
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Did the output register load at the last edge (not stalled, not in reset)?
    always @(posedge clk) upd <= rstn && !stall_in;

    // Monitor: each freshly loaded valid output pops one expectation; while
    // stalled the held outputs must still equal the last one.
    always @(negedge clk) begin
        expT e;
        if (!rstn) begin
            haveLast = 1'b0;
        end else if (valid_out) begin
            if (upd) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got dest %0d with no expected entry", destPhys_out);
                end else begin
                    e = expQ.pop_front();
                    lastExp  = e;
                    haveLast = 1'b1;
                    chk("out_src1", 32'(srcPhys1_out), 32'(e.s1));
                    chk("out_src2", 32'(srcPhys2_out), 32'(e.s2));
                    chk("out_dest", 32'(destPhys_out), 32'(e.d));
                    chk("out_old",  32'(oldDestPhys_out), 32'(e.o));
                end
            end else if (haveLast) begin
                chk("held_src1", 32'(srcPhys1_out), 32'(lastExp.s1));
                chk("held_src2", 32'(srcPhys2_out), 32'(lastExp.s2));
                chk("held_dest", 32'(destPhys_out), 32'(lastExp.d));
                chk("held_old",  32'(oldDestPhys_out), 32'(lastExp.o));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_src1",  32'(srcPhys1_out), 0);
        chk("rst_src2",  32'(srcPhys2_out), 0);
        chk("rst_dest",  32'(destPhys_out), 0);
        chk("rst_old",   32'(oldDestPhys_out), 0);
        chk("rst_count", 32'(free_count_out), 32);
        chk("rst_err",   32'(error_out), 0);
        chk("rst_ready", 32'(ready_out), 1);
        #2 rstn = 1'b1;
        tick();

        // no write
        drive(1, 3, 4, 0, 0, 0, 0, 0); expectOut(3, 4, 0, 0); tick();
        chk("cnt_nowrite", 32'(free_count_out), 32);
        // write to x0 never renames
        drive(1, 1, 2, 0, 1, 0, 0, 0); expectOut(1, 2, 0, 0); tick();
        chk("cnt_x0", 32'(free_count_out), 32);
        // add x5,x1,x2
        drive(1, 1, 2, 5, 1, 0, 0, 0); expectOut(1, 2, 32, 5); tick();
        chk("cnt_alloc1", 32'(free_count_out), 31);
        // add x1,x1,x5: back-to-back sees x5=32, rs1 reads old x1
        drive(1, 1, 5, 1, 1, 0, 0, 0); expectOut(1, 32, 33, 1); tick();
        chk("cnt_alloc2", 32'(free_count_out), 30);
        drive(1, 1, 2, 0, 0, 0, 0, 0); expectOut(33, 2, 0, 0); tick();

        // drain the free list: rd = x2..x31 get tags 34..63
        for (int i = 0; i < 30; i++) begin
            int rd;
            int oldm;
            rd   = i + 2;
            oldm = (rd == 5) ? 32 : rd;
            drive(1, rd, 0, rd, 1, 0, 0, 0);
            expectOut(oldm, 0, 34 + i, oldm);
            if (i == 29) begin
                #1 chk("ready_last_slot", 32'(ready_out), 1);
            end
            tick();
        end
        chk("cnt_empty", 32'(free_count_out), 0);
        chk("ready_empty", 32'(ready_out), 0);

        // empty list, same-cycle retire of 5 must not raise ready
        drive(1, 9, 0, 9, 1, 0, 1, 5);
        #1 chk("ready_same_cycle_retire", 32'(ready_out), 0);
        tick();
        chk("blocked_valid", 32'(valid_out), 0);
        chk("cnt_after_retire", 32'(free_count_out), 1);
        chk("ready_after_retire", 32'(ready_out), 1);
        drive(1, 9, 0, 9, 1, 0, 0, 0); expectOut(41, 0, 5, 41); tick();
        chk("cnt_realloc", 32'(free_count_out), 0);

        drive(0, 0, 0, 0, 0, 0, 1, 6); tick();
        drive(0, 0, 0, 0, 0, 0, 1, 7); tick();
        chk("cnt_two_free", 32'(free_count_out), 2);

        // instruction A: rs1=x1(33) rs2=x2(34) rd=x10(42) -> gets tag 6
        drive(1, 1, 2, 10, 1, 0, 0, 0); expectOut(33, 34, 6, 42); tick();
        chk("cnt_a", 32'(free_count_out), 1);

        // stall 3 cycles with B held; a retire of tag 0 is ignored
        for (int k = 0; k < 3; k++) begin
            drive(1, 10, 3, 11, 1, 1, (k == 0) ? 1 : 0, 0);
            #1 chk("stall_ready", 32'(ready_out), 0);
            tick();
            chk("stall_cnt", 32'(free_count_out), 1);
        end

        // B accepted with a simultaneous retire of 40 at count 1
        drive(1, 10, 3, 11, 1, 0, 1, 40); expectOut(6, 35, 7, 43); tick();
        chk("alloc_retire_cnt", 32'(free_count_out), 1);

        // fill the list to 32, then overflow it
        for (int k = 0; k < 31; k++) begin
            drive(0, 0, 0, 0, 0, 0, 1, 8 + k);
            tick();
        end
        chk("cnt_full", 32'(free_count_out), 32);
        chk("err_before_overflow", 32'(error_out), 0);
        drive(0, 0, 0, 0, 0, 0, 1, 50); tick();
        chk("err_overflow", 32'(error_out), 1);
        chk("cnt_overflow_held", 32'(free_count_out), 32);
        drive(0, 0, 0, 0, 0, 0, 0, 0); tick();
        chk("err_sticky", 32'(error_out), 1);

        // fresh reset, then reset again mid-stream after 10 allocations
        rstn = 1'b0;
        #1 chk("rst2_err", 32'(error_out), 0);
        #1 rstn = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(1, i + 1, 0, i + 1, 1, 0, 0, 0);
            expectOut(i + 1, 0, 32 + i, i + 1);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("cnt_10_alloc", 32'(free_count_out), 22);
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("midrst_valid", 32'(valid_out), 0);
        chk("midrst_src1",  32'(srcPhys1_out), 0);
        chk("midrst_dest",  32'(destPhys_out), 0);
        chk("midrst_old",   32'(oldDestPhys_out), 0);
        chk("midrst_count", 32'(free_count_out), 32);
        #1 rstn = 1'b1;
        tick();
        // RAT back to identity, first allocation is 32 again
        drive(1, 5, 9, 3, 1, 0, 0, 0); expectOut(5, 9, 32, 3); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("cnt_final", 32'(free_count_out), 31);
        chk("queue_empty", 32'(expQ.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
